// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: ring buffer with occupancy count; flush overrides push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and buffers {pc, inst} for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              instRead,
  output logic [ADDR_W-1:0] instAddress,
  input  logic [INST_W-1:0] instData,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectTarget,
  output logic              fetchValid,
  output logic [INST_W-1:0] fetchInst,
  output logic [ADDR_W-1:0] fetchPC,
  input  logic              decodeReady,
  output logic              misalignErr
);

  localparam int unsigned EW = ADDR_W + INST_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              misaligned;

  assign misaligned  = |redirectTarget[1:0];
  assign instAddress = pc;
  assign fetchValid  = (count != '0) && !redirectValid;
  assign pop         = fetchValid && decodeReady;
  // Gated by rst so the read strobe stays low while reset is held.
  assign instRead    = !rst && (state == ST_FETCH) && !redirectValid && (!full || pop);
  assign fetchPC     = empty ? '0 : head[EW-1:INST_W];
  assign fetchInst   = empty ? '0 : head[INST_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (instRead),
    .pop   (pop),
    .flush (redirectValid),
    .wdata ({pc, instData}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_next = state;
    if (redirectValid) state_next = misaligned ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      misalignErr <= 1'b0;
    end else begin
      state <= state_next;
      if (redirectValid) misalignErr <= misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirectValid) begin
      pc <= redirectTarget;
    end else if (instRead) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two configurations driven by shared stimulus, a queue-level model and literal checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        rv  = 1'b0;
  logic [31:0] tgt = '0;

  logic        ird  [2];
  logic [31:0] iad  [2];
  logic [31:0] idat [2];
  logic        fv   [2];
  logic [31:0] finst[2];
  logic [31:0] fpc  [2];
  logic        err  [2];

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  assign idat[0] = memword(iad[0]);
  assign idat[1] = memword(iad[1]);

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .instRead(ird[0]), .instAddress(iad[0]), .instData(idat[0]),
    .redirectValid(rv), .redirectTarget(tgt), .fetchValid(fv[0]), .fetchInst(finst[0]),
    .fetchPC(fpc[0]), .decodeReady(rdy), .misalignErr(err[0])
  );

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .instRead(ird[1]), .instAddress(iad[1]), .instData(idat[1]),
    .redirectValid(rv), .redirectTarget(tgt), .fetchValid(fv[1]), .fetchInst(finst[1]),
    .fetchPC(fpc[1]), .decodeReady(rdy), .misalignErr(err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: a FIFO kept as a shift array (index 0 = head) plus pc/halt/error state.
  int unsigned mdepth[2] = '{2, 4};
  logic [31:0] mreset[2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  int          mcnt[2];
  logic [31:0] mpc[2];
  bit          mhalt[2];
  bit          merr[2];
  logic [31:0] qpc[2][4];
  logic [31:0] qin[2][4];

  task automatic model_step(input int k);
    string p;
    bit xfv, xpop, xrd;
    p = (k == 0) ? "A." : "B.";
    if (rst) begin
      mcnt[k] = 0; mpc[k] = mreset[k]; mhalt[k] = 0; merr[k] = 0;
      chk({p, "rst_instRead"},    {31'd0, ird[k]}, 32'd0);
      chk({p, "rst_fetchValid"},  {31'd0, fv[k]},  32'd0);
      chk({p, "rst_fetchInst"},   finst[k],        32'd0);
      chk({p, "rst_fetchPC"},     fpc[k],          32'd0);
      chk({p, "rst_instAddress"}, iad[k],          mreset[k]);
      chk({p, "rst_misalignErr"}, {31'd0, err[k]}, 32'd0);
      return;
    end
    xfv  = (mcnt[k] > 0) && !rv;
    xpop = xfv && rdy;
    xrd  = !mhalt[k] && !rv && ((mcnt[k] < int'(mdepth[k])) || xpop);
    chk({p, "instAddress"}, iad[k],          mpc[k]);
    chk({p, "instRead"},    {31'd0, ird[k]}, {31'd0, xrd});
    chk({p, "fetchValid"},  {31'd0, fv[k]},  {31'd0, xfv});
    chk({p, "misalignErr"}, {31'd0, err[k]}, {31'd0, merr[k]});
    if (xfv) begin
      chk({p, "fetchPC"},   fpc[k],   qpc[k][0]);
      chk({p, "fetchInst"}, finst[k], qin[k][0]);
    end
    if (rv) begin
      mcnt[k]  = 0;
      mpc[k]   = tgt;
      mhalt[k] = (tgt[1:0] != 2'b00);
      merr[k]  = mhalt[k];
    end else begin
      if (xpop) begin
        for (int j = 0; j < 3; j++) begin
          qpc[k][j] = qpc[k][j+1];
          qin[k][j] = qin[k][j+1];
        end
        mcnt[k]--;
      end
      if (xrd) begin
        qpc[k][mcnt[k]] = mpc[k];
        qin[k][mcnt[k]] = memword(mpc[k]);
        mcnt[k]++;
        mpc[k] = mpc[k] + 32'd4;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic drive(input bit rs, input bit r, input bit v, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = rs; rdy = r; rv = v; tgt = t;
  endtask

  task automatic peek;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    peek;
    chk("lit_rst_instRead", {31'd0, ird[0]}, 32'd0);
    chk("lit_rst_addrB",    iad[1],          32'hFFFF_FFF8);

    // Streaming with decode always ready
    drive(0, 1, 0, 0); peek;
    chk("lit_c1_instRead", {31'd0, ird[0]}, 32'd1);
    chk("lit_c1_addr",     iad[0],          32'h0);
    chk("lit_c1_valid",    {31'd0, fv[0]},  32'd0);
    drive(0, 1, 0, 0); peek;
    chk("lit_c2_inst", finst[0], 32'd1);
    chk("lit_c2_pc",   fpc[0],   32'h0);
    chk("lit_c2_addr", iad[0],   32'h4);
    chk("lit_c2_pcB",  fpc[1],   32'hFFFF_FFF8);
    drive(0, 1, 0, 0); peek;
    chk("lit_c3_inst", finst[0], 32'd2);
    chk("lit_c3_pcB",  fpc[1],   32'hFFFF_FFFC);
    drive(0, 1, 0, 0); peek;
    chk("lit_c4_inst", finst[0], 32'd3);
    chk("lit_c4_pc",   fpc[0],   32'h8);
    chk("lit_c4_pcB",  fpc[1],   32'h0000_0000);
    drive(0, 1, 0, 0); peek;
    chk("lit_c5_pcB",  fpc[1],   32'h0000_0004);

    // Decode stall: FIFO fills, fetch holds
    drive(0, 0, 0, 0); peek;
    chk("lit_c6_pc",   fpc[0],   32'h10);
    drive(0, 0, 0, 0); peek;
    chk("lit_c7_instRead", {31'd0, ird[0]}, 32'd0);
    chk("lit_c7_addr",     iad[0],          32'h18);
    chk("lit_c7_inst",     finst[0],        32'd5);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0); peek;
    chk("lit_c10_addr", iad[0],   32'h18);
    chk("lit_c10_inst", finst[0], 32'd5);
    drive(0, 1, 0, 0); peek;
    chk("lit_c11_inst",     finst[0],        32'd5);
    chk("lit_c11_instRead", {31'd0, ird[0]}, 32'd1);
    drive(0, 1, 0, 0); peek;
    chk("lit_c12_inst", finst[0], 32'd6);
    drive(0, 1, 0, 0); peek;
    chk("lit_c13_inst", finst[0], 32'd7);

    // Redirect with full FIFO
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h40); peek;
    chk("lit_rd_valid",    {31'd0, fv[0]},  32'd0);
    chk("lit_rd_instRead", {31'd0, ird[0]}, 32'd0);
    drive(0, 1, 0, 0); peek;
    chk("lit_rd_addr",  iad[0],         32'h40);
    chk("lit_rd_flush", {31'd0, fv[0]}, 32'd0);
    drive(0, 1, 0, 0); peek;
    chk("lit_rd_pc",   fpc[0],   32'h40);
    chk("lit_rd_inst", finst[0], 32'h11);

    // Misaligned redirect, then recovery
    drive(0, 1, 1, 32'h42);
    drive(0, 1, 0, 0); peek;
    chk("lit_mis_err",      {31'd0, err[0]}, 32'd1);
    chk("lit_mis_instRead", {31'd0, ird[0]}, 32'd0);
    chk("lit_mis_valid",    {31'd0, fv[0]},  32'd0);
    chk("lit_mis_addr",     iad[0],          32'h42);
    drive(0, 1, 0, 0); peek;
    chk("lit_halt_instRead", {31'd0, ird[0]}, 32'd0);
    drive(0, 1, 1, 32'h80);
    drive(0, 1, 0, 0); peek;
    chk("lit_ok_err",      {31'd0, err[0]}, 32'd0);
    chk("lit_ok_instRead", {31'd0, ird[0]}, 32'd1);
    chk("lit_ok_addr",     iad[0],          32'h80);
    drive(0, 1, 0, 0); peek;
    chk("lit_ok_pc", fpc[0], 32'h80);

    // Reset mid-stream with a full FIFO
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0); peek;
    chk("lit_mrst_valid",    {31'd0, fv[0]},  32'd0);
    chk("lit_mrst_instRead", {31'd0, ird[0]}, 32'd0);
    chk("lit_mrst_addr",     iad[0],          32'h0);
    drive(0, 1, 0, 0); peek;
    chk("lit_rel_instRead", {31'd0, ird[0]}, 32'd1);
    chk("lit_rel_addr",     iad[0],          32'h0);
    drive(0, 1, 0, 0); peek;
    chk("lit_rel_pc",   fpc[0],   32'h0);
    chk("lit_rel_inst", finst[0], 32'd1);

    // Random ready/redirect traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0:       t = $urandom & 32'h0000_00FF;
        1:       t = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
        default: t = $urandom & 32'h0000_00FC;
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0, t);
    end
    drive(0, 1, 0, 0);
    peek;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
